mdu_hilo_writer: RTL and testbench

- Iterative multiply/divide unit that produces the HI/LO write interface: wen_HI/wHI and wen_LO/wLO.
- Sits in the EX stage beside the ALU.
- Accepts MULT/MULTU/DIV/DIVU from EX, computes over multiple cycles and pulses one HI/LO write on completion.
- Stalls the pipeline via busy; supports flush via cancel.

---
 rtl/mdu_hilo_writer.sv | 228 ++++++++++++++++++++++
 tb/tb_mdu_hilo_writer.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo_writer.sv
// -----------------------------------------------------------------------------
// mdu_hilo_writer
//
// Iterative multiply/divide unit sitting beside the ALU in EX. Accepts
// MULT/MULTU/DIV/DIVU, computes over several cycles and pulses one HI/LO
// write when the result is ready. The pipeline stalls on busy; cancel flushes
// the operation in flight.
//
//   MULT/MULTU : one registered product cycle, write at T+2
//   DIV/DIVU   : 32-step restoring division on magnitudes, write at T+33
//
// Optional build macro:
//   MDU_DIV0_FAST_EN - a divide by zero skips the iterations and goes straight
//                      to the write cycle (T+1). Results are unchanged.
//
// Ports:
//   clk     in   clock, all state updates on posedge
//   reset   in   synchronous active-high reset
//   start   in   request, sampled only while idle
//   op      in   00=MULT 01=MULTU 10=DIV 11=DIVU
//   src1    in   multiplicand / dividend
//   src2    in   multiplier / divisor
//   cancel  in   flush, aborts the operation in flight
//   busy    out  operation in flight (EX must stall)
//   done    out  one-cycle completion pulse
//   wen_HI  out  HI write enable (done & ~cancel)
//   wHI     out  product[63:32] or remainder
//   wen_LO  out  LO write enable (done & ~cancel)
//   wLO     out  product[31:0] or quotient
// -----------------------------------------------------------------------------
module mdu_hilo_writer #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic        wen_HI,
    output logic [31:0] wHI,
    output logic        wen_LO,
    output logic [31:0] wLO
);

`ifdef MDU_DIV0_FAST_EN
    localparam bit DIV0_FAST = 1'b1;
`else
    localparam bit DIV0_FAST = 1'b0;
`endif

    localparam logic [4:0] LAST_ITER = 5'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIN
    } state_t;

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;

    // Operand / datapath registers, loaded only at acceptance.
    logic [31:0] a_reg;            // multiplicand
    logic [31:0] b_reg;            // multiplier, or divisor magnitude
    logic [31:0] quot_reg;         // dividend shifting out, quotient shifting in
    logic [31:0] rem_reg;          // partial remainder
    logic        mul_signed_reg;
    logic        neg_q_reg;        // negate quotient at the end
    logic        neg_r_reg;        // negate remainder at the end

    logic        accept;
    logic        op_signed;
    logic [31:0] src1_mag, src2_mag;

    logic [63:0] mul_a_ext, mul_b_ext, product;

    logic [32:0] div_shifted;
    logic [31:0] div_trial;
    logic        div_fits;
    logic [31:0] quot_step, rem_step;
    logic [31:0] quot_final, rem_final;

    // ------------------------------------------------------------------
    // Acceptance and operand conditioning
    // ------------------------------------------------------------------
    assign accept    = (state_reg == S_IDLE) && start && !cancel;
    assign op_signed = ~op[0];
    assign src1_mag  = (op_signed && src1[31]) ? (~src1 + 32'd1) : src1;
    assign src2_mag  = (op_signed && src2[31]) ? (~src2 + 32'd1) : src2;

    // ------------------------------------------------------------------
    // Multiply: the low 64 bits of a 64x64 product of the extended
    // operands are the correct two's-complement result for either sign mode.
    // ------------------------------------------------------------------
    assign mul_a_ext = {{32{mul_signed_reg & a_reg[31]}}, a_reg};
    assign mul_b_ext = {{32{mul_signed_reg & b_reg[31]}}, b_reg};
    assign product   = mul_a_ext * mul_b_ext;

    // ------------------------------------------------------------------
    // One restoring-division step. The remainder is always below the
    // divisor, so the shifted value fits in 33 bits and the subtraction
    // result (when it fits) fits in 32 bits.
    // A zero divisor makes every step "fit", which naturally yields
    // quotient=all ones and remainder=dividend magnitude; the sign fix-up
    // then gives HI=src1 and LO=0xFFFFFFFF (or 1 for a negative signed
    // dividend).
    // ------------------------------------------------------------------
    assign div_shifted = {rem_reg, quot_reg[31]};
    assign div_fits    = (div_shifted >= {1'b0, b_reg});
    assign div_trial   = div_shifted[31:0] - b_reg;
    assign rem_step    = div_fits ? div_trial : div_shifted[31:0];
    assign quot_step   = {quot_reg[30:0], div_fits};
    assign quot_final  = neg_q_reg ? (~quot_step + 32'd1) : quot_step;
    assign rem_final   = neg_r_reg ? (~rem_step + 32'd1) : rem_step;

    // ------------------------------------------------------------------
    // Next-state and result logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;

        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    if (op[1]) begin
                        state_next = S_DIV;
                        cnt_next   = '0;
                        if (DIV0_FAST && (src2 == '0)) begin
                            state_next = S_FIN;
                            hi_next    = src1;
                            lo_next    = (op_signed && src1[31]) ? 32'h0000_0001
                                                                 : 32'hFFFF_FFFF;
                        end
                    end else begin
                        state_next = S_MUL;
                    end
                end
            end

            S_MUL: begin
                if (cancel) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_FIN;
                    hi_next    = product[63:32];
                    lo_next    = product[31:0];
                end
            end

            S_DIV: begin
                cnt_next = cnt_reg + 5'd1;
                if (cancel) begin
                    state_next = S_IDLE;
                end else if (cnt_reg == LAST_ITER) begin
                    state_next = S_FIN;
                    hi_next    = rem_final;
                    lo_next    = quot_final;
                end
            end

            S_FIN: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            hi_reg         <= '0;
            lo_reg         <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            quot_reg       <= '0;
            rem_reg        <= '0;
            mul_signed_reg <= 1'b0;
            neg_q_reg      <= 1'b0;
            neg_r_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;

            if (accept) begin
                a_reg          <= src1;
                b_reg          <= op[1] ? src2_mag : src2;
                quot_reg       <= src1_mag;
                rem_reg        <= '0;
                mul_signed_reg <= op_signed;
                neg_q_reg      <= op_signed & (src1[31] ^ src2[31]);
                neg_r_reg      <= op_signed & src1[31];
            end else if (state_reg == S_DIV) begin
                quot_reg <= quot_step;
                rem_reg  <= rem_step;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Data holds between writes; only the enables qualify it.
    // ------------------------------------------------------------------
    assign busy   = (state_reg != S_IDLE);
    assign done   = (state_reg == S_FIN);
    assign wen_HI = done & ~cancel;
    assign wen_LO = done & ~cancel;
    assign wHI    = hi_reg;
    assign wLO    = lo_reg;

endmodule

// File: tb/tb_mdu_hilo_writer.sv
// -----------------------------------------------------------------------------
// tb_mdu_hilo_writer
//
// Self-checking bench for mdu_hilo_writer. Expected results are computed by a
// small behavioural model when an operation is issued, pushed to a queue and
// popped/compared when the DUT pulses done. Inputs change and outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mdu_hilo_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        cancel;
    logic        busy;
    logic        done;
    logic        wen_HI;
    logic [31:0] wHI;
    logic        wen_LO;
    logic [31:0] wLO;

    always #5 clk = ~clk;

    mdu_hilo_writer dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .src1   (src1),
        .src2   (src2),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .wen_HI (wen_HI),
        .wHI    (wHI),
        .wen_LO (wen_LO),
        .wLO    (wLO)
    );

`ifdef MDU_DIV0_FAST_EN
    localparam int DIV0_LAT = 1;
`else
    localparam int DIV0_LAT = 33;
`endif
    localparam int BUDGET = 100;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Behavioural reference: plain integer arithmetic on 64-bit values.
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        int          sa;
        int          sb;
        longint      p;
        longint      q;
        longint      r;
        logic [63:0] pu;
        sa = a;
        sb = b;
        case (o)
            2'b00: begin
                p = longint'(sa) * longint'(sb);
                e.hi = p[63:32]; e.lo = p[31:0]; e.lat = 2;
            end
            2'b01: begin
                pu = {32'd0, a} * {32'd0, b};
                e.hi = pu[63:32]; e.lo = pu[31:0]; e.lat = 2;
            end
            2'b10: begin
                if (b == 32'd0) begin
                    e.hi = a; e.lo = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF; e.lat = DIV0_LAT;
                end else begin
                    q = longint'(sa) / longint'(sb);
                    r = longint'(sa) % longint'(sb);
                    e.hi = r[31:0]; e.lo = q[31:0]; e.lat = 33;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a; e.lo = 32'hFFFF_FFFF; e.lat = DIV0_LAT;
                end else begin
                    e.hi = a % b; e.lo = a / b; e.lat = 33;
                end
            end
        endcase
        return e;
    endfunction

    // Drive a request at the current falling edge; returns at the falling
    // edge of cycle T+1. Unless held, start drops and the operands are
    // scrambled so late operand changes are exercised.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, input bit push);
        op    = o;
        src1  = a;
        src2  = b;
        start = 1'b1;
        if (push) sb_q.push_back(model(o, a, b));
        @(negedge clk);
        if (!hold) begin
            start = 1'b0;
            src1  = $urandom;
            src2  = $urandom;
            op    = 2'($urandom);
        end
    endtask

    // Bounded wait for done, counting cycles since acceptance and any cycle
    // in which busy was low before completion.
    task automatic wait_done(input int lat0, output int lat, output int busy_low);
        lat      = lat0;
        busy_low = 0;
        while (1) begin
            if (!busy) busy_low++;
            if (done || lat >= BUDGET) break;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        int wen_seen;
        reset  = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        op     = 2'b00;
        src1   = '0;
        src2   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_tests++;
        if ({busy, done, wen_HI, wen_LO} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 0000", {busy, done, wen_HI, wen_LO});
        end
        n_tests++;
        if ({wHI, wLO} !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_data got %h want 0", {wHI, wLO});
        end
        // Reset in the middle of a division: back to idle, no write ever.
        issue(2'b10, 32'd100, 32'd3, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midop_busy got %b want 0", busy);
        end
        wen_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (wen_HI !== 1'b0 || wen_LO !== 1'b0 || done !== 1'b0) wen_seen++;
            @(negedge clk);
        end
        n_tests++;
        if (wen_seen != 0 || wHI !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_midop_write got %0d writes HI=%h want 0 writes HI=0", wen_seen, wHI);
        end
        $display("[TB] reset checks done");
    endtask

    task automatic test_mul();
        logic [1:0]  t_op [6] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00};
        logic [31:0] t_a  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                                  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        logic [31:0] t_b  [6] = '{32'h0000_0002, 32'h0000_0002, 32'h8000_0000,
                                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678};
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          bl;
        exp_t        e;
        for (int i = 0; i < 10; i++) begin
            if (i < 6) begin
                o = t_op[i]; a = t_a[i]; b = t_b[i];
            end else begin
                o = {1'b0, 1'($urandom)}; a = $urandom; b = $urandom;
            end
            issue(o, a, b, 1'b0, 1'b1);
            wait_done(1, lat, bl);
            e = sb_q.pop_front();
            $display("[TB] mul op=%0d src1=%h src2=%h -> HI=%h LO=%h lat=%0d", o, a, b, wHI, wLO, lat);
            n_tests++;
            if (lat != e.lat) begin
                n_fail++; $display("FAIL mul_latency got %0d want %0d", lat, e.lat);
            end
            n_tests++;
            if ({wHI, wLO} !== {e.hi, e.lo}) begin
                n_fail++; $display("FAIL mul_data got %h_%h want %h_%h", wHI, wLO, e.hi, e.lo);
            end
            n_tests++;
            if ({wen_HI, wen_LO} !== 2'b11 || bl != 0) begin
                n_fail++; $display("FAIL mul_wen_busy got wen=%b busy_low=%0d want 11 0", {wen_HI, wen_LO}, bl);
            end
            @(negedge clk);
            n_tests++;
            if (busy !== 1'b0 || done !== 1'b0 || wHI !== e.hi || wLO !== e.lo) begin
                n_fail++;
                $display("FAIL mul_after got busy=%b done=%b HI=%h LO=%h want 0 0 %h %h", busy, done, wHI, wLO, e.hi, e.lo);
            end
        end
    endtask

    task automatic test_div();
        logic [1:0]  t_op [9] = '{2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11, 2'b11};
        logic [31:0] t_a  [9] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd7, 32'hFFFF_FFFF,
                                  32'd5, 32'hFFFF_FFF8, 32'd5, 32'hDEAD_BEEF};
        logic [31:0] t_b  [9] = '{32'd2, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,
                                  32'd0, 32'd0, 32'd0, 32'h0001_0000};
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        int          bl;
        exp_t        e;
        for (int i = 0; i < 13; i++) begin
            if (i < 9) begin
                o = t_op[i]; a = t_a[i]; b = t_b[i];
            end else begin
                o = {1'b1, 1'($urandom)}; a = $urandom; b = $urandom_range(1, 32'hFFFF);
                if (i[0]) b = {b[15:0], 16'($urandom)};
            end
            issue(o, a, b, 1'b0, 1'b1);
            wait_done(1, lat, bl);
            e = sb_q.pop_front();
            $display("[TB] div op=%0d src1=%h src2=%h -> HI=%h LO=%h lat=%0d", o, a, b, wHI, wLO, lat);
            n_tests++;
            if (lat != e.lat) begin
                n_fail++; $display("FAIL div_latency got %0d want %0d", lat, e.lat);
            end
            n_tests++;
            if ({wHI, wLO} !== {e.hi, e.lo}) begin
                n_fail++; $display("FAIL div_data got %h_%h want %h_%h", wHI, wLO, e.hi, e.lo);
            end
            n_tests++;
            if ({wen_HI, wen_LO} !== 2'b11 || bl != 0) begin
                n_fail++; $display("FAIL div_wen_busy got wen=%b busy_low=%0d want 11 0", {wen_HI, wen_LO}, bl);
            end
            @(negedge clk);
            n_tests++;
            if (busy !== 1'b0 || done !== 1'b0 || wHI !== e.hi || wLO !== e.lo) begin
                n_fail++;
                $display("FAIL div_after got busy=%b done=%b HI=%h LO=%h want 0 0 %h %h", busy, done, wHI, wLO, e.hi, e.lo);
            end
        end
    endtask

    task automatic test_cancel();
        int   wen_seen;
        int   lat;
        int   bl;
        exp_t e;
        // Cancel a division at T+10.
        issue(2'b10, 32'd1000, 32'd7, 1'b0, 1'b0);
        wen_seen = 0;
        for (int k = 1; k < 10; k++) begin
            if (wen_HI !== 1'b0 || wen_LO !== 1'b0) wen_seen++;
            @(negedge clk);
        end
        cancel = 1'b1;
        if (wen_HI !== 1'b0 || wen_LO !== 1'b0) wen_seen++;
        @(negedge clk);
        cancel = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL cancel_div_busy got %b want 0", busy);
        end
        // New MULTU 3*4 at T+11.
        issue(2'b01, 32'd3, 32'd4, 1'b0, 1'b1);
        wait_done(1, lat, bl);
        e = sb_q.pop_front();
        $display("[TB] cancel then multu 3*4 -> HI=%h LO=%h lat=%0d", wHI, wLO, lat);
        n_tests++;
        if (lat != 2 || {wHI, wLO} !== {e.hi, e.lo} || {wen_HI, wen_LO} !== 2'b11) begin
            n_fail++;
            $display("FAIL cancel_next_op got lat=%0d %h_%h wen=%b want 2 %h_%h 11", lat, wHI, wLO, {wen_HI, wen_LO}, e.hi, e.lo);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (wen_HI !== 1'b0 || wen_LO !== 1'b0) wen_seen++;
        end
        n_tests++;
        if (wen_seen != 0) begin
            n_fail++; $display("FAIL cancel_no_write got %0d writes want 0", wen_seen);
        end
        // Cancel during the completion cycle: done stays, enables drop.
        issue(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b1);
        wait_done(1, lat, bl);
        e = sb_q.pop_front();
        cancel = 1'b1;
        #1;
        n_tests++;
        if (done !== 1'b1 || {wen_HI, wen_LO} !== 2'b00 || {wHI, wLO} !== {e.hi, e.lo}) begin
            n_fail++;
            $display("FAIL cancel_fin got done=%b wen=%b %h_%h want 1 00 %h_%h", done, {wen_HI, wen_LO}, wHI, wLO, e.hi, e.lo);
        end
        $display("[TB] cancel in FIN: done=%b wen=%b", done, {wen_HI, wen_LO});
        @(negedge clk);
        // Start together with cancel in IDLE is ignored.
        op     = 2'b00;
        src1   = 32'd6;
        src2   = 32'd7;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL cancel_idle_start got busy=%b want 0", busy);
        end
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL cancel_idle_done got done=%b want 0", done);
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        int   bl;
        exp_t e;
        // start held high: second acceptance only after FIN.
        issue(2'b11, 32'd9, 32'd3, 1'b1, 1'b1);
        wait_done(1, lat, bl);
        e = sb_q.pop_front();
        $display("[TB] b2b first divu 9/3 -> HI=%h LO=%h lat=%0d", wHI, wLO, lat);
        n_tests++;
        if (lat != 33 || {wHI, wLO} !== {e.hi, e.lo} || {wen_HI, wen_LO} !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_first got lat=%0d %h_%h wen=%b want 33 %h_%h 11", lat, wHI, wLO, {wen_HI, wen_LO}, e.hi, e.lo);
        end
        sb_q.push_back(model(2'b11, 32'd9, 32'd3));
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_gap got busy=%b want 0", busy);
        end
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_reaccept got busy=%b want 1", busy);
        end
        wait_done(1, lat, bl);
        e = sb_q.pop_front();
        $display("[TB] b2b second divu 9/3 -> HI=%h LO=%h lat=%0d", wHI, wLO, lat);
        n_tests++;
        if (lat != 33 || {wHI, wLO} !== {e.hi, e.lo} || bl != 0) begin
            n_fail++;
            $display("FAIL b2b_second got lat=%0d %h_%h busy_low=%0d want 33 %h_%h 0", lat, wHI, wLO, bl, e.hi, e.lo);
        end
        @(negedge clk);
        // A start with new operands in the middle of a division is ignored.
        issue(2'b11, 32'd100, 32'd7, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        op    = 2'b11;
        src1  = 32'd1000;
        src2  = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(6, lat, bl);
        e = sb_q.pop_front();
        $display("[TB] b2b divu 100/7 with mid start -> HI=%h LO=%h lat=%0d", wHI, wLO, lat);
        n_tests++;
        if (lat != 33 || {wHI, wLO} !== {e.hi, e.lo} || {wen_HI, wen_LO} !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_midstart got lat=%0d %h_%h wen=%b want 33 %h_%h 11", lat, wHI, wLO, {wen_HI, wen_LO}, e.hi, e.lo);
        end
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL b2b_midstart_idle got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_cancel();
        test_back_to_back();
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_left got %0d entries want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
